// File: rtl/bubble_sort_engine_if.sv
// Signal bundle between the bubble-sort engine and whatever drives and observes it.
// The DUT takes the slave view; the stimulus side takes the master view.
interface bubble_sort_engine_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             step_en;
   logic [WIDTH-1:0] in_num_0;
   logic [WIDTH-1:0] in_num_1;
   logic [WIDTH-1:0] in_num_2;
   logic [WIDTH-1:0] in_num_3;
   logic [WIDTH-1:0] sorted_nums_0;
   logic [WIDTH-1:0] sorted_nums_1;
   logic [WIDTH-1:0] sorted_nums_2;
   logic [WIDTH-1:0] sorted_nums_3;
   logic             sorting_done;
   logic             busy;
   logic [1:0]       cmp_idx;
   logic [7:0]       swap_count;
   logic [1:0]       dbg_state;

   // Handshake: start is a one-cycle request that is accepted only while the
   // engine is idle or done (busy low); step_en is a level qualifier that
   // executes one compare per clock while busy and is ignored otherwise.
   modport master (
      output start, step_en, in_num_0, in_num_1, in_num_2, in_num_3,
      input  sorted_nums_0, sorted_nums_1, sorted_nums_2, sorted_nums_3,
      input  sorting_done, busy, cmp_idx, swap_count, dbg_state
   );

   modport slave (
      input  start, step_en, in_num_0, in_num_1, in_num_2, in_num_3,
      output sorted_nums_0, sorted_nums_1, sorted_nums_2, sorted_nums_3,
      output sorting_done, busy, cmp_idx, swap_count, dbg_state
   );
endinterface

// File: rtl/bubble_sort_engine.sv
// Four-element bubble sort that performs one compare/swap per step_en cycle,
// exposing the working array, compare position and swap count as it goes.
module bubble_sort_engine #(
   parameter int WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bubble_sort_engine_if.slave   bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SORT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0][WIDTH-1:0]   a_q, a_d;
   logic [1:0]              pass_q, pass_d;
   logic [1:0]              idx_q, idx_d;
   logic                    swapped_q, swapped_d;
   logic [7:0]              swap_count_q, swap_count_d;

   logic [WIDTH-1:0]        left_val;
   logic [WIDTH-1:0]        right_val;
   logic                    do_swap;
   logic                    swapped_now;
   logic                    pass_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         a_q          <= '0;
         pass_q       <= 2'd0;
         idx_q        <= 2'd0;
         swapped_q    <= 1'b0;
         swap_count_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         pass_q       <= pass_d;
         idx_q        <= idx_d;
         swapped_q    <= swapped_d;
         swap_count_q <= swap_count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      pass_d       = pass_q;
      idx_d        = idx_q;
      swapped_d    = swapped_q;
      swap_count_d = swap_count_q;
      left_val     = a_q[idx_q];
      right_val    = a_q[idx_q + 2'd1];
      // Strict compare keeps equal elements in place, so the sort is stable.
      do_swap      = left_val > right_val;
      swapped_now  = swapped_q | do_swap;
      pass_end     = idx_q == (2'd2 - pass_q);

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               a_d[0]       = bus.in_num_0;
               a_d[1]       = bus.in_num_1;
               a_d[2]       = bus.in_num_2;
               a_d[3]       = bus.in_num_3;
               pass_d       = 2'd0;
               idx_d        = 2'd0;
               swapped_d    = 1'b0;
               swap_count_d = 8'd0;
               state_d      = ST_SORT;
            end
         end
         ST_SORT: begin
            if (bus.step_en) begin
               if (do_swap) begin
                  a_d[idx_q]         = right_val;
                  a_d[idx_q + 2'd1]  = left_val;
                  if (swap_count_q != 8'hFF) swap_count_d = swap_count_q + 8'd1;
               end
               if (pass_end) begin
                  idx_d     = 2'd0;
                  swapped_d = 1'b0;
                  // A swap-free pass proves the array is already ordered.
                  if (pass_q == 2'd2 || !swapped_now) state_d = ST_DONE;
                  else                                pass_d  = pass_q + 2'd1;
               end else begin
                  idx_d     = idx_q + 2'd1;
                  swapped_d = swapped_now;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.sorted_nums_0 = a_q[0];
   assign bus.sorted_nums_1 = a_q[1];
   assign bus.sorted_nums_2 = a_q[2];
   assign bus.sorted_nums_3 = a_q[3];
   assign bus.busy          = state_q == ST_SORT;
   assign bus.sorting_done  = state_q == ST_DONE;
   assign bus.cmp_idx       = (state_q == ST_SORT) ? idx_q : 2'd0;
   assign bus.swap_count    = swap_count_q;
   assign bus.dbg_state     = state_q;
endmodule

// File: doc/bubble_sort_engine.md
# bubble_sort_engine

Sequential bubble-sort engine for four unsigned nibbles. It sits directly upstream of the seven-segment display stage and drives its bubble-sort inputs: the four working registers and the done flag. Sorting advances one compare/swap per `step_en` pulse, so the display can show each intermediate state of the array. It also reports the current compare position and a running swap count for visualisation.

## Interface
- `WIDTH`, default 4: bit width of each element. Compare is unsigned.
- `clk`  in  1: system clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle request to load `in_num_0..3` and begin sorting. Honoured only in IDLE or DONE.
- `step_en`  in  1: advance enable. One compare/swap is executed per cycle in which it is high during SORT.
- `in_num_0`..`in_num_3`  in  WIDTH each: unsorted operands, sampled on the accepted `start` edge.
- `sorted_nums_0`..`sorted_nums_3`  out  WIDTH each: working registers. Index 0 ends up holding the smallest value. The registers are visible mid-sort.
- `sorting_done`  out  1: high in DONE.
- `busy`  out  1: high in SORT.
- `cmp_idx`  out  2: left index of the next compare (0..2). Reads 0 outside SORT.
- `swap_count`  out  8: swaps performed since the last accepted `start`. Saturates at 255.

## Operation
- **States:** IDLE, SORT, DONE. Reset enters IDLE.
- **IDLE/DONE + `start`:**
  - Load `a[i] <= in_num_i`.
  - Clear `swap_count`, `pass`, `idx`, and the `swapped` flag.
  - Go to SORT.
  - `step_en` in the same cycle is ignored.
- **SORT + `step_en`:**
  - Compare `a[idx] > a[idx+1]` (strictly greater). If true, swap the two elements in the same edge, set `swapped`, and increment `swap_count`.
  - Equal values are never swapped, so the sort is stable.
- **End of pass:** a pass ends at `idx == 2 - pass`.
  - If `pass == 2`, or no swap occurred in this pass (including the final compare), go to DONE.
  - Otherwise `pass <= pass + 1`, `idx <= 0`, and `swapped <= 0`.
- **Otherwise within a pass:** `idx <= idx + 1`.
- **SORT without `step_en`:** all state holds.
- **`start` while in SORT:** ignored; the sort continues unchanged.
- **DONE:** array and `swap_count` hold until the next accepted `start`.
- **Compare counts:** at most 6 compares (3+2+1). An already-sorted input finishes after 3 compares (one pass with no swaps).
- **`pass`:** 2-bit internal counter, range 0..2.

## Timing
- **Reset values:**
  - `sorted_nums_0..3` = 0
  - `sorting_done` = 0
  - `busy` = 0
  - `cmp_idx` = 0
  - `swap_count` = 0
- **Asynchronous reset:** `rst_n` low forces all of the above immediately, regardless of state, including mid-sort. Release is sampled on the next `clk` edge.
- **Start:** accepted at edge E0. `busy` = 1, `sorting_done` = 0, and the loaded values appear on `sorted_nums_*` after E0.
- **Step:** each `step_en`-qualified edge updates the array, `cmp_idx` and `swap_count` together. There is zero additional latency.
- **Final compare:** `busy` falls and `sorting_done` rises on the same edge as the final compare. The sorted array is valid in that same cycle.
- **Outputs:** all outputs are registered, with no combinational path from inputs.

## Test plan
1. **Reset:** hold `rst_n` = 0 with random inputs -> all outputs 0. Release and wait 5 cycles without `start` -> outputs remain 0, state stays IDLE.
2. **Mixed input:** load 3,1,2,0 with `step_en` tied high -> `busy` after E0. Compares at E1..E6 give `cmp_idx` sequence 0,1,2,0,1,0. After E6: sorted 0,1,2,3, `swap_count` = 5, `sorting_done` = 1, `busy` = 0.
3. **Early exit:** load 1,2,3,4 with `step_en` high -> `sorting_done` after E3, `swap_count` = 0, array unchanged.
4. **Reverse input with throttled steps:** load 9,8,7,6 with `step_en` pulsed every 4th cycle -> array holds between pulses. Done after the 6th pulse with 6,7,8,9 and `swap_count` = 6.
5. **Duplicates:** load 5,5,2,5 -> 2,5,5,5 with `swap_count` = 2. Equal pairs are never swapped.
6. **Restart and mid-sort reset:**
   - Pulse `start` with 0,0,0,0 after 2 compares of 4,3,2,1 -> ignored; the sort completes to 1,2,3,4.
   - Restart with 4,3,2,1, then drop `rst_n` after 2 compares -> outputs 0 immediately.
   - Restart after reset -> the sort completes normally.
